// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: FSM state encoding,
// instruction word field positions and the ALU opcode type.
package instr_issuer_pkg;

   localparam int INSTR_WIDTH = 12;
   localparam int SLOT_W      = 3;

   // Instruction word field positions.
   localparam int OP0_PE_MSB  = 10;
   localparam int OP0_PE_LSB  = 8;
   localparam int OP1_PE_MSB  = 6;
   localparam int OP1_PE_LSB  = 4;
   localparam int OP0_IMM_BIT = 3;
   localparam int OP1_IMM_BIT = 2;
   localparam int ALU_OP_MSB  = 1;
   localparam int ALU_OP_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } issuer_state_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_SUB  = 2'd1,
      ALU_MUL  = 2'd2,
      ALU_PASS = 2'd3
   } alu_op_t;

   // Extract the ALU opcode field of an instruction word.
   function automatic alu_op_t instr_alu_op(input logic [INSTR_WIDTH-1:0] word);
      return alu_op_t'(word[ALU_OP_MSB:ALU_OP_LSB]);
   endfunction

endpackage

// File: rtl/instr_issuer_operand_check.sv
// Operand legality rule: a PE-output operand must name a strictly earlier
// slot than the one issuing the word. Pure combinational, reusable by the
// scheduler.
module operand_check
   import instr_issuer_pkg::*;
(
   input  logic [INSTR_WIDTH-1:0] word,
   input  logic [SLOT_W-1:0]      slot,
   output logic                   legal
);

   logic op0_bad;
   logic op1_bad;

   // Each non-immediate operand must reference a PE slot below the current one.
   always_comb begin
      op0_bad = !word[OP0_IMM_BIT] && (word[OP0_PE_MSB:OP0_PE_LSB] >= slot);
      op1_bad = !word[OP1_IMM_BIT] && (word[OP1_PE_MSB:OP1_PE_LSB] >= slot);
      legal   = !(op0_bad || op1_bad);
   end

   // Bits that do not take part in the rule (operand MSBs, ALU opcode).
   logic unused_bits;
   assign unused_bits = ^{word[OP0_PE_MSB+1], word[OP1_PE_MSB+1], word[ALU_OP_MSB:ALU_OP_LSB]};

endmodule

// File: rtl/instr_issuer.sv
// Program sequencer for the 12-bit instruction port: buffers a host-loaded
// program, then streams one legality-checked word per cycle on start.
module instr_issuer
   import instr_issuer_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int INSTR_W = 12
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_instr,
   output logic               load_ready,
   input  logic               start,
   input  logic               clear,
   output logic [INSTR_W-1:0] instruction,
   output logic               issue_valid,
   output logic [2:0]         slot,
   output logic               busy,
   output logic               done,
   output logic               fault,
   output logic [2:0]         fault_slot,
   output logic [3:0]         prog_count
);

   localparam int AW = $clog2(DEPTH);

   issuer_state_t      state_q, state_d;
   logic [3:0]         prog_count_q, prog_count_d;
   logic [2:0]         rd_ptr_q, rd_ptr_d;
   logic               fault_q, fault_d;
   logic [2:0]         fault_slot_q, fault_slot_d;
   logic [INSTR_W-1:0] buf_q [DEPTH];
   logic [INSTR_W-1:0] buf_d [DEPTH];

   logic [INSTR_W-1:0] cur_word;
   logic               cur_legal;
   logic               load_fire;
   logic               last_slot;

   assign cur_word  = buf_q[rd_ptr_q[AW-1:0]];
   assign last_slot = ({1'b0, rd_ptr_q} == (prog_count_q - 4'd1));

   operand_check u_operand_check (
      .word  (cur_word),
      .slot  (rd_ptr_q),
      .legal (cur_legal)
   );

   // Next-state logic: loading, start/clear handling and the issue walk.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      prog_count_d = prog_count_q;
      rd_ptr_d     = rd_ptr_q;
      fault_d      = fault_q;
      fault_slot_d = fault_slot_q;
      buf_d        = buf_q;
      load_ready   = (state_q == ST_IDLE) && (prog_count_q < 4'(DEPTH));
      load_fire    = load_valid && load_ready;

      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               prog_count_d = 4'd0;
            end else begin
               if (load_fire) begin
                  buf_d[prog_count_q[AW-1:0]] = load_instr;
                  prog_count_d                = prog_count_q + 4'd1;
               end
               // A word loaded in the same cycle as start joins the run.
               if (start) begin
                  rd_ptr_d = 3'd0;
                  state_d  = (prog_count_d == 4'd0) ? ST_DONE : ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (cur_legal) begin
               if (last_slot) state_d  = ST_DONE;
               else           rd_ptr_d = rd_ptr_q + 3'd1;
            end else begin
               fault_d      = 1'b1;
               fault_slot_d = rd_ptr_q;
               state_d      = ST_FAULT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (clear) begin
               prog_count_d = 4'd0;
               fault_d      = 1'b0;
               fault_slot_d = 3'd0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from registered state and buffer contents.
   always_comb begin
      issue_valid = (state_q == ST_ISSUE) && cur_legal;
      instruction = issue_valid ? cur_word : '0;
      slot        = rd_ptr_q;
      busy        = (state_q == ST_ISSUE);
      done        = (state_q == ST_DONE);
      fault       = fault_q;
      fault_slot  = fault_slot_q;
      prog_count  = prog_count_q;
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q      <= ST_IDLE;
         prog_count_q <= 4'd0;
         rd_ptr_q     <= 3'd0;
         fault_q      <= 1'b0;
         fault_slot_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         prog_count_q <= prog_count_d;
         rd_ptr_q     <= rd_ptr_d;
         fault_q      <= fault_d;
         fault_slot_q <= fault_slot_d;
      end
   end

   // Program buffer storage.
   always_ff @(posedge clock) begin
      // NOTE: the buffer is not reset; prog_count gates which entries are meaningful.
      buf_q <= buf_d;
   end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: clean run, faults, full buffer, empty
// program, reset mid-issue and load coinciding with start.
module tb_instr_issuer;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_valid;
   logic [11:0] load_instr;
   logic        load_ready;
   logic        start;
   logic        clear;
   logic [11:0] instruction;
   logic        issue_valid;
   logic [2:0]  slot;
   logic        busy;
   logic        done;
   logic        fault;
   logic [2:0]  fault_slot;
   logic [3:0]  prog_count;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clock = ~clock;

   instr_issuer #(.DEPTH(8), .INSTR_W(12)) dut (
      .clock       (clock),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_instr  (load_instr),
      .load_ready  (load_ready),
      .start       (start),
      .clear       (clear),
      .instruction (instruction),
      .issue_valid (issue_valid),
      .slot        (slot),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .fault_slot  (fault_slot),
      .prog_count  (prog_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [11:0] w);
      load_valid = 1'b1;
      load_instr = w;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic check_issue(input string tag, input logic [11:0] w, input logic [2:0] k);
      check({tag, "_valid"}, issue_valid, 1'b1);
      check({tag, "_instr"}, instruction, w);
      check({tag, "_slot"}, slot, k);
   endtask

   logic [11:0] clean_prog [3] = '{12'h12C, 12'h004, 12'h105};
   logic [11:0] full_prog  [8];

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_instr = '0; start = 1'b0; clear = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // Reset state.
      check("rst_prog_count", prog_count, 4'd0);
      check("rst_load_ready", load_ready, 1'b1);
      check("rst_instr", instruction, 12'h000);
      check("rst_valid", issue_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_fault", fault, 1'b0);
      check("rst_fault_slot", fault_slot, 3'd0);

      // Clean run: slots at t+1..t+3, done at t+4.
      foreach (clean_prog[i]) load(clean_prog[i]);
      check("clean_count", prog_count, 4'd3);
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         check_issue($sformatf("clean_s%0d", k), clean_prog[k], 3'(k));
         check("clean_busy", busy, 1'b1);
         tick();
      end
      check("clean_done", done, 1'b1);
      check("clean_busy_low", busy, 1'b0);
      check("clean_done_instr", instruction, 12'h000);
      tick();
      check("clean_done_pulse", done, 1'b0);
      check("clean_retained", prog_count, 4'd3);

      // Fault at slot 0: 0x004 references PE 0 from slot 0.
      pulse_clear();
      check("clr_count", prog_count, 4'd0);
      load(12'h004);
      pulse_start();
      check("f0_valid", issue_valid, 1'b0);
      check("f0_instr", instruction, 12'h000);
      check("f0_fault_early", fault, 1'b0);
      tick();
      check("f0_fault", fault, 1'b1);
      check("f0_fault_slot", fault_slot, 3'd0);
      check("f0_busy", busy, 1'b0);
      pulse_start();
      tick();
      check("f0_sticky", fault, 1'b1);
      check("f0_no_issue", issue_valid, 1'b0);
      check("f0_no_load", load_ready, 1'b0);
      pulse_clear();
      check("f0_cleared", fault, 1'b0);
      check("f0_clr_count", prog_count, 4'd0);
      check("f0_clr_ready", load_ready, 1'b1);

      // Fault at slot 2: op1 references PE 2 from slot 2.
      load(12'h00C); load(12'h004); load(12'h12B);
      pulse_start();
      check_issue("f2_s0", 12'h00C, 3'd0); tick();
      check_issue("f2_s1", 12'h004, 3'd1); tick();
      check("f2_valid", issue_valid, 1'b0);
      tick();
      check("f2_fault", fault, 1'b1);
      check("f2_fault_slot", fault_slot, 3'd2);
      pulse_clear();

      // Full buffer: nine offers, eight accepted.
      for (int i = 0; i < 8; i++) full_prog[i] = {4'(i), 4'(7 - i), 2'b11, 2'(i)};
      for (int i = 0; i < 9; i++) begin
         load_valid = 1'b1;
         load_instr = (i < 8) ? full_prog[i] : 12'hFFF;
         #1;
         check($sformatf("full_ready_%0d", i), load_ready, (i < 8) ? 1'b1 : 1'b0);
         tick();
      end
      load_valid = 1'b0;
      check("full_count", prog_count, 4'd8);
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         check_issue($sformatf("full_s%0d", k), full_prog[k], 3'(k));
         tick();
      end
      check("full_done", done, 1'b1);
      tick();
      pulse_clear();

      // Empty program: done at t+1, no issue.
      pulse_start();
      check("empty_done", done, 1'b1);
      check("empty_valid", issue_valid, 1'b0);
      check("empty_busy", busy, 1'b0);
      tick();
      check("empty_done_pulse", done, 1'b0);
      check("empty_valid2", issue_valid, 1'b0);

      // Reset while slot 2 of a 5-word program is presented.
      for (int i = 0; i < 5; i++) load({4'(i), 4'(i), 4'b1101});
      pulse_start();
      tick(); tick();
      check("rmid_slot", slot, 3'd2);
      check("rmid_valid_pre", issue_valid, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rmid_valid", issue_valid, 1'b0);
      check("rmid_busy", busy, 1'b0);
      check("rmid_count", prog_count, 4'd0);
      check("rmid_ready", load_ready, 1'b1);
      tick();
      check("rmid_stays_idle", issue_valid, 1'b0);

      // Simultaneous load and start: third word joins the run.
      load(12'h22E); load(12'h00D);
      load_valid = 1'b1; load_instr = 12'h018; start = 1'b1;
      tick();
      load_valid = 1'b0; start = 1'b0;
      check_issue("sim_s0", 12'h22E, 3'd0); tick();
      check_issue("sim_s1", 12'h00D, 3'd1); tick();
      check_issue("sim_s2", 12'h018, 3'd2); tick();
      check("sim_done", done, 1'b1);
      check("sim_count", prog_count, 4'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Program sequencer on the transmit side of the processor's 12-bit instruction port. It buffers a short dataflow program loaded by a host. On `start` it streams one instruction per cycle to the scheduler, with slot index k issued k cycles after the first. Before issuing each instruction it applies the scheduler's operand-legality rule (a PE-output operand must name an earlier slot), so illegal programs are stopped at the source instead of faulting inside the array.

## Interface
- `DEPTH`, 8: program slots; power of two, 2..8 (the PE-select field is 3 bits).
- `INSTR_W`, 12: instruction width; fixed at 12.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high. The clock is named `clock` and the reset `reset`; synchronous active-high reset is fixed.
- `load_valid`  in  1: host offers `load_instr`.
- `load_instr`  in  12: instruction word to append.
- `load_ready`  out  1: high when the state is IDLE and `prog_count < DEPTH`.
- `start`  in  1: begin issuing the buffered program from slot 0.
- `clear`  in  1: empty the buffer and clear the fault; honoured in IDLE and FAULT only.
- `instruction`  out  12: instruction to the processor; 12'h000 when not issuing.
- `issue_valid`  out  1: `instruction` is a legal, issued word this cycle.
- `slot`  out  3: index of the slot being presented.
- `busy`  out  1: state is ISSUE.
- `done`  out  1: one-cycle pulse when the program completes.
- `fault`  out  1: sticky illegal-operand flag.
- `fault_slot`  out  3: slot that faulted; valid while `fault` is high.
- `prog_count`  out  4: number of words in the buffer.

## Operation
- **States:** IDLE, ISSUE, DONE, FAULT.
- **Word fields:**
  - [11:8] op0
  - [7:4] op1
  - [3] op0 immediate (0 = PE reference via [10:8])
  - [2] op1 immediate (0 = PE reference via [6:4])
  - [1:0] ALU op
- **IDLE, load:** when `load_valid && load_ready`, the word is written at index `prog_count` and `prog_count` increments. When full, the load is refused (`load_ready` = 0) and nothing changes.
- **IDLE, start:**
  - `start` with `prog_count` = 0: go to DONE; no issue.
  - Otherwise: go to ISSUE with `rd_ptr` = 0.
  - Load handshake and `start` in the same cycle: the word is written and is included in the run.
- **IDLE, clear:** `prog_count` ← 0. `clear` takes priority over a load and over `start` in the same cycle.
- **ISSUE legality check:** the word at `rd_ptr` is legal unless either of these holds:
  - [3] = 0 and [10:8] ≥ `rd_ptr`
  - [2] = 0 and [6:4] ≥ `rd_ptr`
- **ISSUE, legal word:** `instruction` = buf[`rd_ptr`], `issue_valid` = 1, `slot` = `rd_ptr`. If `rd_ptr` = `prog_count`−1, go to DONE; otherwise `rd_ptr`++.
- **ISSUE, illegal word:** `instruction` = 0, `issue_valid` = 0. Set `fault`, latch `fault_slot` = `rd_ptr`, go to FAULT.
- **ISSUE inputs:** `start`, `clear` and loads are ignored (`load_ready` = 0).
- **DONE:** `done` = 1 for exactly one cycle, then IDLE. The buffer is retained, so a later `start` re-runs it.
- **FAULT:** holds `fault` and `fault_slot`. Only `clear` (empties buffer, drops `fault`, goes to IDLE) or `reset` exits. `start` is ignored.
- **Arithmetic:** `rd_ptr` is 3 bits. Comparisons are unsigned 3-bit. `prog_count` is 4 bits and saturates at `DEPTH` by the `load_ready` gating; it never wraps.

## Timing
- **Reset:** after the reset edge:
  - State IDLE; `prog_count`, `rd_ptr`, `fault`, `fault_slot` = 0.
  - `instruction` = 0; `issue_valid`, `busy`, `done` = 0.
  - `load_ready` = 1.
- **Reset mid-operation:** any state returns to IDLE with an empty buffer on the next edge. No partial issue continues.
- **Outputs:** decoded from registered state and buffer contents; no input-to-output combinational path except none.
- **Issue cadence:** for `start` sampled at edge t, slot k is presented in cycle t+1+k. For a clean program, `done` is high in cycle t+1+`prog_count`.
- **Fault timing:** a fault at slot k shows `issue_valid` = 0 in cycle t+1+k; `fault` is high from cycle t+2+k.
- **Load throughput:** one word per cycle; accepted at the edge where `load_valid && load_ready`.
- **System alignment:** slot k matches processor `global_counter` = k only if the processor is reset in the same cycle `start` is sampled; that is the system integrator's responsibility.

## Structure
- Add to the shared `internal_defines.vh` package:
  - `issuer_state_t` enum.
  - Field localparams: `OP0_PE_MSB`/`LSB`, `OP1_PE_MSB`/`LSB`, `OP0_IMM_BIT` = 3, `OP1_IMM_BIT` = 2.
  - Reuse of the existing `alu_op_t` for [1:0].
- The buffer is a `DEPTH`×12 register array inside the module.
- One combinational sub-module, `operand_check`: inputs are the word and the slot; output is `legal`. The same rule is reusable by the scheduler.

## Test plan
- **Clean run:** load 0x12C, 0x004, 0x105; `start` at t → `instruction` 0x12C, 0x004, 0x105 with `issue_valid` = 1 and `slot` = 0,1,2 in t+1..t+3; `done` at t+4; `busy` low from t+4.
- **Fault at slot 0:** load 0x004; `start` → `issue_valid` = 0 at t+1, `fault` = 1 and `fault_slot` = 0 from t+2. A later `start` changes nothing. `clear` → IDLE, `prog_count` = 0, `fault` = 0.
- **Full buffer:** 9 consecutive `load_valid` cycles → 8 accepted, `load_ready` = 0 on the 9th, `prog_count` = 8. `start` issues all 8 words in order (all-immediate words).
- **Empty program:** `start` with `prog_count` = 0 → `done` at t+1; `issue_valid` never asserts.
- **Reset mid-issue:** assert `reset` while `slot` = 2 of a 5-word program → next cycle IDLE, `issue_valid` = 0, `prog_count` = 0, `load_ready` = 1.
- **Simultaneous load and start:** 2 words already loaded, then a third load handshake and `start` in the same cycle → 3 slots issued, `done` at t+4.
